seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-pattern detector; the parametrised successor to the fixed 11101 Moore detector.
- Pattern, length (1..MAX_LEN) and overlap/non-overlap mode are loadable at run time.
- Input is qualified by a valid strobe, and a saturating match counter is provided.
- Sits on a serial bitstream (line decoder / framing logic) and flags frame or sync words.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of match counter.
- DEF_PATTERN, 8'b0001_1101, pattern loaded at reset, right-aligned.
- DEF_LEN, 5, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  one-cycle request to load new configuration.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W=$clog2(MAX_LEN)+1  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- x_valid  in  1  qualifies x; x is ignored when low.
- x  in  1  serial data bit.
- y  out  1  registered match pulse (Moore style).
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  one-cycle pulse when a cfg_load is rejected.

Behaviour:
- Reset (rst=1 at clk edge):
  - y=0, match_count=0, cfg_err=0.
  - history cleared, fill=0.
  - pattern/len/overlap = DEF_*.
  - rst overrides all other inputs in the same cycle.
- History:
  - Register hist[MAX_LEN-1:0]; on an accepted bit (x_valid=1, no accepted cfg_load), hist <= {hist[MAX_LEN-2:0], x}.
  - fill increments, saturating at MAX_LEN.
- Match condition, evaluated on the accepted bit using the post-shift value:
  - fill_next >= len, and
  - low len bits of hist_next == low len bits of pattern.
  - Bits above len are don't-care.
- Output timing:
  - y=1 exactly in the cycle after the accepted bit that completes a match; otherwise 0.
  - Cycles with x_valid=0 never assert y.
  - Back-to-back matches (possible only with overlap, or len=1) give y high on consecutive cycles.
- Overlap mode: fill is unchanged after a match, so match suffixes may begin the next match.
- Non-overlap mode: on a match, fill <= 0 (hist contents kept but masked by fill). The next match needs len fresh bits.
- match_count:
  - Increments with each match, registered with y.
  - Holds at 2^CNT_W-1, never wraps.
- Configuration:
  - Accepted when 1 <= cfg_len <= MAX_LEN.
  - On acceptance: pattern/len/overlap update, hist and fill clear, match_count clears, y=0 next cycle.
  - Rejected (cfg_len==0 or > MAX_LEN): configuration, history and count unchanged; cfg_err=1 for one cycle.
- Simultaneous cfg_load and x_valid:
  - Accepted config: config wins and the bit is discarded.
  - Rejected config: the bit is processed normally under the old config.
- A mid-stream config change never completes a match using bits received before the load.
- len=1: every accepted bit equal to pattern[0] matches, in both modes.

Decomposition:
- Package seq_det_pkg:
  - LEN_W function ($clog2(MAX_LEN)+1).
  - Mode constants OVERLAP/NON_OVERLAP.
  - Default pattern/len constants (11101, 5).
- One natural sub-module, seq_det_sat_counter: CNT_W saturating counter with inc and sync clear, reused for match_count.
- fill uses the same sub-module, width LEN_W, saturating at MAX_LEN.
- Everything else stays in the top module.

Test Plan:
- Reset defaults, overlap: stream 1,1,1,0,1,1,1,0,1 with x_valid=1 -> y pulses after bits 5 and 9; match_count=2.
- Same stream after cfg_load(pattern=11101, len=5, overlap=0) -> single y pulse after bit 5; match_count=1.
- cfg_load(pattern=1010, len=4, overlap=1), stream 1010101 -> y after bits 4 and 6, count=2; repeat with overlap=0 -> y after bit 4 only, count=1.
- cfg_load with cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses each time; config and count unchanged; a following 11101 still detected.
- cfg_load accepted in the same cycle as x_valid=1 with the final pattern bit -> no y; count reads 0; history empty.
- CNT_W=2, len=1, pattern=1, 5 consecutive valid 1s with x_valid gaps between them -> five single-cycle y pulses, none during gaps; match_count holds at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Mode encodings and reset-time defaults live here so every file agrees on them.
package seq_det_pkg;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Right-aligned 11101, the sync word of the original fixed detector.
  localparam logic [31:0] DEF_PATTERN_C = 32'b1_1101;
  localparam int          DEF_LEN_C     = 5;

  // Width able to hold any length from 0 to max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Configuration, serial-input and result signals of the pattern detector.
// Handshake: x_valid qualifies x for one cycle and there is no back-pressure;
// cfg_load is a one-cycle request, always consumed in the cycle it is high.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               x_valid;
  logic               x;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x,
    input  y, match_count, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x,
    output y, match_count, cfg_err
  );

endinterface

// File: rtl/seq_det_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clr and rst both zero it.
module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// valid-qualified input and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEF_PATTERN_C[MAX_LEN-1:0],
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter logic               DEF_OVERLAP = OVERLAP
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam int               LEN_W    = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  // Only the post-shift value is ever compared, so the oldest bit need not be kept.
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;
  logic               cfg_ok;
  logic               cfg_accept;
  logic               cfg_reject;
  logic               bit_accept;
  logic               match;

  assign cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= FILL_MAX);
  assign cfg_accept = bus.cfg_load && cfg_ok;
  assign cfg_reject = bus.cfg_load && !cfg_ok;
  assign bit_accept = bus.x_valid && !cfg_accept;

  assign hist_next = {hist, bus.x};
  assign fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
  // Shifting all-ones by MAX_LEN yields zero, so a full-length mask is all ones.
  assign len_mask  = ~({MAX_LEN{1'b1}} << len_q);
  assign match     = bit_accept && (fill_next >= len_q) &&
                     (((hist_next ^ pattern_q) & len_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= DEF_PATTERN;
      len_q       <= LEN_W'(DEF_LEN);
      overlap_q   <= DEF_OVERLAP;
      hist        <= '0;
      bus.y       <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.y       <= match;
      bus.cfg_err <= cfg_reject;
      if (cfg_accept) begin
        pattern_q <= bus.cfg_pattern;
        len_q     <= bus.cfg_len;
        overlap_q <= bus.cfg_overlap;
        hist      <= '0;
      end else if (bit_accept) begin
        hist      <= hist_next[MAX_LEN-2:0];
      end
    end
  end

  // fill tracks how many received bits may take part in the next match.
  seq_det_sat_counter #(.W(LEN_W), .MAX(FILL_MAX)) u_fill (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_accept || (match && (overlap_q == NON_OVERLAP))),
    .inc   (bit_accept),
    .count (fill)
  );

  seq_det_sat_counter #(.W(CNT_W)) u_match_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_accept),
    .inc   (match),
    .count (bus.match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (16-bit and 2-bit counters) share
// stimulus and are checked against a queue-of-received-bits reference model.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               x_valid;
  logic               x;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(16)) bus_a ();
  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(2))  bus_b ();

  assign bus_a.cfg_load    = cfg_load;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_len     = cfg_len;
  assign bus_a.cfg_overlap = cfg_overlap;
  assign bus_a.x_valid     = x_valid;
  assign bus_a.x           = x;
  assign bus_b.cfg_load    = cfg_load;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.cfg_len     = cfg_len;
  assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_b.x_valid     = x_valid;
  assign bus_b.x           = x;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Expected word per cycle: {cfg_err, y, count_b[1:0], count_a[15:0]}.
  logic [19:0] exp_q[$];

  // Reference model: the bits received since the last reset/load/non-overlap match.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ov;
  bit                 m_bits[$];
  int                 m_cnt_a;
  int                 m_cnt_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat   = 8'b0001_1101;
    m_len   = 5;
    m_ov    = 1'b1;
    m_bits.delete();
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  task automatic model_step(input bit ld, input logic [MAX_LEN-1:0] pat,
                            input logic [LEN_W-1:0] len, input bit ov,
                            input bit xv, input bit xb);
    bit e_err = 1'b0;
    bit e_y   = 1'b0;
    bit hit;
    if (ld && len >= 1 && len <= MAX_LEN) begin
      m_pat = pat;
      m_len = int'(len);
      m_ov  = ov;
      m_bits.delete();
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      e_err = ld;
      if (xv) begin
        m_bits.push_back(xb);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
          if (hit) begin
            e_y = 1'b1;
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
            if (!m_ov) m_bits.delete();
          end
        end
      end
    end
    exp_q.push_back({e_err, e_y, m_cnt_b[1:0], m_cnt_a[15:0]});
  endtask

  task automatic idle_inputs();
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    x_valid     = 1'b0;
    x           = 1'b0;
  endtask

  task automatic cycle(input bit ld, input logic [MAX_LEN-1:0] pat,
                       input logic [LEN_W-1:0] len, input bit ov,
                       input bit xv, input bit xb);
    logic [19:0] e;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    x_valid     = xv;
    x           = xb;
    @(posedge clk);
    model_step(ld, pat, len, ov, xv, xb);
    #1;
    e = exp_q.pop_front();
    check("y_a",     32'(bus_a.y),           32'(e[18]));
    check("y_b",     32'(bus_b.y),           32'(e[18]));
    check("err_a",   32'(bus_a.cfg_err),     32'(e[19]));
    check("err_b",   32'(bus_b.cfg_err),     32'(e[19]));
    check("count_a", 32'(bus_a.match_count), 32'(e[15:0]));
    check("count_b", 32'(bus_b.match_count), 32'(e[17:16]));
    idle_inputs();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, '0, '0, 1'b0, 1'b1, bits[i]);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input bit ov);
    cycle(1'b1, pat, len, ov, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    // Reset with a rejected config and a valid bit present: reset must win.
    rst      = 1'b1;
    cfg_load = 1'b1;
    x_valid  = 1'b1;
    x        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_y",     32'(bus_a.y),           32'd0);
    check("rst_err",   32'(bus_a.cfg_err),     32'd0);
    check("rst_count", 32'(bus_a.match_count), 32'd0);
    rst = 1'b0;
    idle_inputs();

    // Default 11101 overlap detector.
    send_bits(16'b1_1101_1101, 9);
    check("dflt_ovl_count", 32'(bus_a.match_count), 32'd2);

    load(8'b1_1101, 4'd5, 1'b0);
    send_bits(16'b1_1101_1101, 9);
    check("nonovl_count", 32'(bus_a.match_count), 32'd1);

    load(8'b1010, 4'd4, 1'b1);
    send_bits(16'b101_0101, 7);
    check("1010_ovl_count", 32'(bus_a.match_count), 32'd2);
    load(8'b1010, 4'd4, 1'b0);
    send_bits(16'b101_0101, 7);
    check("1010_nonovl_count", 32'(bus_a.match_count), 32'd1);

    // Rejected loads leave 11101/overlap in place; last reject carries a bit.
    load(8'b1_1101, 4'd5, 1'b1);
    load(8'hff, 4'd0, 1'b0);
    load(8'hff, 4'd9, 1'b0);
    cycle(1'b1, 8'h00, 4'd15, 1'b0, 1'b1, 1'b1);
    send_bits(16'b1101, 4);
    check("after_reject_count", 32'(bus_a.match_count), 32'd1);

    // Accepted load colliding with the final pattern bit discards that bit.
    load(8'b1_1101, 4'd5, 1'b1);
    send_bits(16'b1110, 4);
    cycle(1'b1, 8'b1_1101, 4'd5, 1'b1, 1'b1, 1'b1);
    send_bits(16'b1, 1);
    check("collide_count", 32'(bus_a.match_count), 32'd0);

    // Full-length pattern, back to back.
    load(8'b1011_0011, 4'd8, 1'b1);
    send_bits(16'b1011_0011_1011_0011, 16);

    // len=1 with gaps; the 2-bit counter must stick at 3.
    load(8'b1, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    check("len1_sat_b", 32'(bus_b.match_count), 32'd3);
    check("len1_cnt_a", 32'(bus_a.match_count), 32'd5);

    // Randomised traffic: short patterns dominate so matches stay frequent.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        logic [LEN_W-1:0] rl;
        rl = ($urandom_range(0, 1) == 1) ? LEN_W'($urandom_range(1, 3))
                                         : LEN_W'($urandom_range(0, 10));
        cycle(1'b1, MAX_LEN'($urandom), rl, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cycle(1'b0, '0, '0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
